// File: rtl/seg7_scan_driver.sv
// Purpose : time-multiplexed N-digit hex 7-segment driver with lamp test, blanking, latch, DP and leading-zero blanking.
// Latency : Seg/Dig/Frame are registered, 1 cycle behind the scan counters and digit latches.
// Backpressure: none; the scan is free-running and the display pins cannot stall it.
//
// Ports:
//   CLK    system clock, all state on the rising edge
//   RST    synchronous active-high reset; aborts the current slot and restarts at digit 0
//   D      4*DIGITS hex nibbles, D[4i+3:4i] = digit i (digit 0 least significant)
//   DP     per-digit decimal point, 1 = lit
//   LT_N   lamp test, active low (all segments lit while a digit is enabled)
//   BI_N   blanking, active low
//   LE     latch enable: 0 = load D/DP every edge, 1 = hold
//   LZB    leading-zero blanking enable
//   Seg    {dp,g,f,e,d,c,b,a} for the enabled digit, polarity set by SEG_POL
//   Dig    one-hot digit enable, polarity set by DIG_POL
//   Frame  one-cycle pulse after the last slot of each full scan
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000,
    parameter int SEG_POL  = 1,
    parameter int DIG_POL  = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   D,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  LT_N,
    input  logic                  BI_N,
    input  logic                  LE,
    input  logic                  LZB,
    output logic [7:0]            Seg,
    output logic [DIGITS-1:0]     Dig,
    output logic                  Frame
);

    // Counter widths; both are kept at least one bit wide so that the
    // degenerate single-digit / tiny-divider builds still elaborate.
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    // Pin-level "nothing lit" values after polarity is applied.
    localparam logic [7:0]        SEG_OFF = (SEG_POL != 0) ? 8'h00 : 8'hFF;
    localparam logic [DIGITS-1:0] DIG_OFF = (DIG_POL != 0) ? '0 : '1;

    // Slot phase: the first cycle of every slot is a dead gap so the
    // previous digit's segments never bleed onto the next digit.
    typedef enum logic {
        PH_DEAD = 1'b0,
        PH_ON   = 1'b1
    } phase_t;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   latch_d;
    logic [DIGITS-1:0]     latch_dp;

    phase_t                phase;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_lead_zero;
    logic                  zero_run;
    logic [DIGITS-1:0]     dig_sel;
    logic [7:0]            seg_on;
    logic                  cnt_wrap;
    logic                  idx_wrap;

    // Hex to {g,f,e,d,c,b,a}, active high.
    function automatic logic [6:0] dec7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3f;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5b;
            4'h3: s = 7'h4f;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6d;
            4'h6: s = 7'h7d;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7f;
            4'h9: s = 7'h6f;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7c;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5e;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign cnt_wrap = (cnt == CNT_MAX);
    assign idx_wrap = (idx == IDX_MAX);
    assign phase    = (cnt == '0) ? PH_DEAD : PH_ON;

    // Select the active digit's nibble/DP and work out whether it is a
    // leading zero. Walking from the most significant digit down, zero_run
    // stays set only while every nibble seen so far (i..DIGITS-1) is zero.
    always_comb begin
        cur_nib       = 4'h0;
        cur_dp        = 1'b0;
        cur_lead_zero = 1'b0;
        dig_sel       = '0;
        zero_run      = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (latch_d[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                cur_nib       = latch_d[4*i +: 4];
                cur_dp        = latch_dp[i];
                // Digit 0 always shows, so a value of zero reads "0".
                cur_lead_zero = (i != 0) && zero_run;
                dig_sel[i]    = 1'b1;
            end
        end
    end

    // Segment pattern during the ON phase, highest priority first.
    always_comb begin
        seg_on = {cur_dp, dec7(cur_nib)};
        if (!LT_N) begin
            seg_on = 8'hFF;
        end else if (!BI_N) begin
            seg_on = 8'h00;
        end else if (LZB && cur_lead_zero) begin
            seg_on = 8'h00;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt      <= '0;
            idx      <= '0;
            latch_d  <= '0;
            latch_dp <= '0;
            Seg      <= SEG_OFF;
            Dig      <= DIG_OFF;
            Frame    <= 1'b0;
        end else begin
            // Transparent-low latch, realised as a clock-enabled register.
            if (!LE) begin
                latch_d  <= D;
                latch_dp <= DP;
            end

            // Prescaler and digit index.
            if (cnt_wrap) begin
                cnt <= '0;
                idx <= idx_wrap ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            Frame <= cnt_wrap && idx_wrap;

            case (phase)
                PH_DEAD: begin
                    Seg <= SEG_OFF;
                    Dig <= DIG_OFF;
                end
                default: begin
                    Seg <= (SEG_POL != 0) ? seg_on  : ~seg_on;
                    Dig <= (DIG_POL != 0) ? dig_sel : ~dig_sel;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT pins (shared by both polarity variants)
    logic        rst  = 1'b1;
    logic [15:0] d    = '0;
    logic [3:0]  dp   = '0;
    logic        lt_n = 1'b1;
    logic        bi_n = 1'b1;
    logic        le   = 1'b0;
    logic        lzb  = 1'b0;

    logic [7:0] seg_a, seg_b;
    logic [3:0] dig_a, dig_b;
    logic       frame_a, frame_b;

    // Staged stimulus, applied to the pins on the next falling edge
    logic        st_rst  = 1'b1;
    logic [15:0] st_d    = '0;
    logic [3:0]  st_dp   = '0;
    logic        st_lt_n = 1'b1;
    logic        st_bi_n = 1'b1;
    logic        st_le   = 1'b0;
    logic        st_lzb  = 1'b0;

    int checks   = 0;
    int failures = 0;

    seg7_scan_driver #(.DIGITS(N), .SCAN_DIV(SD), .SEG_POL(1), .DIG_POL(0)) dut_a (
        .CLK(clk), .RST(rst), .D(d), .DP(dp), .LT_N(lt_n), .BI_N(bi_n),
        .LE(le), .LZB(lzb), .Seg(seg_a), .Dig(dig_a), .Frame(frame_a)
    );

    seg7_scan_driver #(.DIGITS(N), .SCAN_DIV(SD), .SEG_POL(0), .DIG_POL(1)) dut_b (
        .CLK(clk), .RST(rst), .D(d), .DP(dp), .LT_N(lt_n), .BI_N(bi_n),
        .LE(le), .LZB(lzb), .Seg(seg_b), .Dig(dig_b), .Frame(frame_b)
    );

    // Expected response in logical (active-high) terms
    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       frame;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] dec7_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                  7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

    // Reference model state: edges since reset release, and latched digits
    int          m_n   = 0;
    logic [15:0] m_ld  = '0;
    logic [3:0]  m_ldp = '0;
    logic        started = 1'b0;

    // Output that appears after an edge, from time-since-reset arithmetic:
    // position within slot = n mod SD, digit = (n / SD) mod N.
    function automatic exp_t model_out(input logic r, input int n, input logic [15:0] ld,
                                       input logic [3:0] ldp, input logic ltn,
                                       input logic bin, input logic lz);
        exp_t e;
        int pos;
        int di;
        logic [15:0] upper;
        logic [3:0]  nib;
        e = '0;
        if (r) return e;
        pos     = n % SD;
        di      = (n / SD) % N;
        e.frame = (pos == SD - 1) && (di == N - 1);
        if (pos != 0) begin
            e.dig = 4'(1 << di);
            upper = ld >> (4 * di);
            nib   = upper[3:0];
            if (!ltn)                            e.seg = 8'hFF;
            else if (!bin)                       e.seg = 8'h00;
            else if (lz && di > 0 && upper == 0) e.seg = 8'h00;
            else                                 e.seg = {ldp[di], dec7_tab[nib]};
        end
        return e;
    endfunction

    task automatic run(input int k);
        repeat (k) begin
            @(negedge clk);
            rst  = st_rst;
            d    = st_d;
            dp   = st_dp;
            lt_n = st_lt_n;
            bi_n = st_bi_n;
            le   = st_le;
            lzb  = st_lzb;
            exp_q.push_back(model_out(st_rst, m_n, m_ld, m_ldp, st_lt_n, st_bi_n, st_lzb));
            if (st_rst) begin
                m_n   = 0;
                m_ld  = '0;
                m_ldp = '0;
            end else begin
                m_n++;
                if (!st_le) begin
                    m_ld  = st_d;
                    m_ldp = st_dp;
                end
            end
            started = 1'b1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
        end
    endtask

    // Monitor: one expected entry per clock edge, compared 1 time unit later
    initial begin : monitor
        exp_t e;
        wait (started);
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty t=%0t got=none want=entry", $time);
            end else begin
                e = exp_q.pop_front();
                chk("seg_a",   seg_a,              e.seg);
                chk("dig_a",   {4'h0, dig_a},      {4'h0, ~e.dig});
                chk("frame_a", {7'h0, frame_a},    {7'h0, e.frame});
                chk("seg_b",   seg_b,              ~e.seg);
                chk("dig_b",   {4'h0, dig_b},      {4'h0, e.dig});
                chk("frame_b", {7'h0, frame_b},    {7'h0, e.frame});
            end
        end
    end

    initial begin : stimulus
        // Reset held for three cycles
        st_rst = 1'b1;
        run(3);

        // Plain scan of 1234, no leading-zero blanking
        st_rst = 1'b0; st_d = 16'h1234; st_le = 1'b0; st_lzb = 1'b0;
        run(40);

        // Leading-zero blanking
        st_lzb = 1'b1; st_d = 16'h0050;
        run(32);
        st_d = 16'h0000;
        run(32);

        // Latch hold
        st_lzb = 1'b0; st_d = 16'hABCD;
        run(4);
        st_le = 1'b1; st_d = 16'h0000;
        run(32);
        st_le = 1'b0;
        run(32);

        // Lamp test over blanking, blanking, DP on an 8
        st_lt_n = 1'b0; st_bi_n = 1'b0;
        run(20);
        st_lt_n = 1'b1;
        run(20);
        st_bi_n = 1'b1; st_dp = 4'b0001; st_d = 16'h0008;
        run(20);

        // Reset in the middle of an ON slot
        st_dp = 4'b0000; st_d = 16'h0001;
        run(5);
        while ((m_n % SD) != 2) run(1);
        st_rst = 1'b1;
        run(1);
        st_rst = 1'b0;
        run(24);

        // Randomised traffic; nibbles are zero half the time so LZB matters
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int j = 0; j < 4; j++)
                    st_d[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
                st_dp   = 4'($urandom_range(0, 15));
                st_le   = ($urandom_range(0, 3) == 0);
                st_lzb  = 1'($urandom_range(0, 1));
                st_lt_n = ($urandom_range(0, 9) != 0);
                st_bi_n = ($urandom_range(0, 9) != 0);
            end
            st_rst = ($urandom_range(0, 99) == 0);
            run(1);
        end

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
